// File: rtl/gate_direction_detector_pkg.sv
// Shared types for the parking-gate direction detector: FSM states and the
// {outer, inner} sensor-pair encodings the FSM decodes.
package gate_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENT1,
      ENT2,
      ENT3,
      EXT1,
      EXT2,
      EXT3,
      FAULT
   } gate_state_e;

   // Pair is always {outer beam, inner beam}; 1 means the beam is blocked.
   localparam logic [1:0] CLEAR    = 2'b00;
   localparam logic [1:0] OUT_ONLY = 2'b10;
   localparam logic [1:0] BOTH     = 2'b11;
   localparam logic [1:0] IN_ONLY  = 2'b01;

endpackage

// File: rtl/gate_direction_detector_if.sv
// Gate bundle: raw beam inputs toward the detector, counter strobes and
// status coming back out of it.
interface gate_direction_detector_if;

   logic sensor_a;
   logic sensor_b;
   logic incr;
   logic decr;
   logic busy;
   logic fault;

   modport master (
      output sensor_a,
      output sensor_b,
      input  incr,
      input  decr,
      input  busy,
      input  fault
   );

   modport slave (
      input  sensor_a,
      input  sensor_b,
      output incr,
      output decr,
      output busy,
      output fault
   );

endinterface

// File: rtl/gate_direction_detector_sensor_filter.sv
// One beam sensor: a metastability synchronizer followed by a filter that
// only accepts a new level after it has held for FILTER_CYCLES cycles.
module sensor_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = $clog2(FILTER_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   level_q, level_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   sync_level;

   assign sync_level = sync_q[SYNC_STAGES-1];
   assign level      = level_q;

   // The counter restarts whenever the synchronized level agrees with the
   // accepted one, so only an unbroken run of disagreement flips the level.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync_level == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync_level;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_direction_detector.sv
// Decodes filtered outer/inner beam sequences into one-cycle entry (incr)
// and exit (decr) strobes for the occupancy counter.
module gate_direction_detector
   import gate_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3
) (
   input  logic clk,
   input  logic reset,
   gate_direction_detector_if.slave bus
);

   logic        f_a, f_b;
   logic [1:0]  pair;
   gate_state_e state_q, state_d;
   logic        incr_q, incr_d;
   logic        decr_q, decr_d;
   logic        busy_q, busy_d;
   logic        fault_q, fault_d;

   sensor_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter_a (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.sensor_a),
      .level (f_a)
   );

   sensor_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter_b (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.sensor_b),
      .level (f_b)
   );

   assign pair = {f_a, f_b};

   // Next state plus the values the outputs take alongside it, so every
   // output is a flop that moves on the same edge as the state it reflects.
   always_comb begin
      state_d = state_q;
      incr_d  = 1'b0;
      decr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pair == OUT_ONLY)     state_d = ENT1;
            else if (pair == IN_ONLY) state_d = EXT1;
            else if (pair == BOTH)    state_d = FAULT;
         end
         ENT1: begin
            if (pair == BOTH)         state_d = ENT2;
            else if (pair == CLEAR)   state_d = IDLE;
            else if (pair == IN_ONLY) state_d = FAULT;
         end
         ENT2: begin
            if (pair == IN_ONLY)       state_d = ENT3;
            else if (pair == OUT_ONLY) state_d = ENT1;
            else if (pair == CLEAR)    state_d = FAULT;
         end
         ENT3: begin
            if (pair == CLEAR) begin
               state_d = IDLE;
               incr_d  = 1'b1;
            end else if (pair == BOTH) begin
               state_d = ENT2;
            end else if (pair == OUT_ONLY) begin
               state_d = FAULT;
            end
         end
         EXT1: begin
            if (pair == BOTH)          state_d = EXT2;
            else if (pair == CLEAR)    state_d = IDLE;
            else if (pair == OUT_ONLY) state_d = FAULT;
         end
         EXT2: begin
            if (pair == OUT_ONLY)     state_d = EXT3;
            else if (pair == IN_ONLY) state_d = EXT1;
            else if (pair == CLEAR)   state_d = FAULT;
         end
         EXT3: begin
            if (pair == CLEAR) begin
               state_d = IDLE;
               decr_d  = 1'b1;
            end else if (pair == BOTH) begin
               state_d = EXT2;
            end else if (pair == IN_ONLY) begin
               state_d = FAULT;
            end
         end
         FAULT: begin
            if (pair == CLEAR) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d != IDLE);
      fault_d = (state_d == FAULT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         incr_q  <= 1'b0;
         decr_q  <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         incr_q  <= incr_d;
         decr_q  <= decr_d;
         busy_q  <= busy_d;
         fault_q <= fault_d;
      end
   end

   assign bus.incr  = incr_q;
   assign bus.decr  = decr_q;
   assign bus.busy  = busy_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_gate_direction_detector.sv
// Directed bench for gate_direction_detector: stimulus queues expected
// strobes with their due cycle, a monitor matches every strobe it sees.
module tb_gate_direction_detector;

   localparam int LATENCY = 6;
   localparam logic [1:0] K_INCR = 2'd1;
   localparam logic [1:0] K_DECR = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      int         cycle;
   } exp_t;

   logic clk;
   logic reset;
   int   cycle;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];

   gate_direction_detector_if bus ();

   gate_direction_detector #(
      .SYNC_STAGES   (2),
      .FILTER_CYCLES (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle = cycle + 1;

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks = n_checks + 1;
      if (actual != expected) begin
         n_fail = n_fail + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Drive a sensor pair at a falling edge and hold it; a completing pair
   // books the strobe it must cause LATENCY edges later.
   task automatic apply_stimulus(input logic [1:0] ab, input int hold, input logic [1:0] kind);
      exp_t e;
      @(negedge clk);
      bus.sensor_a = ab[1];
      bus.sensor_b = ab[0];
      if (kind != 2'd0) begin
         e.kind  = kind;
         e.cycle = cycle + LATENCY;
         exp_q.push_back(e);
      end
      repeat (hold) @(posedge clk);
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      check_output(name, int'({bus.incr, bus.decr, bus.busy, bus.fault}), 0);
   endtask

   // Monitor: every strobe must match the oldest booked one in kind and cycle.
   always @(negedge clk) begin
      if (!reset && (bus.incr || bus.decr)) begin
         check_output("incr_decr_exclusive", int'(bus.incr && bus.decr), 0);
         check_output("busy_low_with_pulse", int'(bus.busy), 0);
         if (exp_q.size() == 0) begin
            check_output("unexpected_pulse", int'({bus.incr, bus.decr}), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("pulse_kind", int'({bus.decr, bus.incr}), int'(e.kind));
            check_output("pulse_cycle", cycle, e.cycle);
         end
      end
   end

   initial begin
      int busy_seen;
      n_checks     = 0;
      n_fail       = 0;
      cycle        = 0;
      reset        = 1'b1;
      bus.sensor_a = 1'b0;
      bus.sensor_b = 1'b0;

      // 1: reset and quiet idle
      repeat (3) @(posedge clk);
      check_idle("reset_outputs");
      reset = 1'b0;
      for (int i = 0; i < 20; i++) check_idle("idle_quiet");

      // 2: entry
      apply_stimulus(2'b10, 10, 2'd0);
      check_output("entry_busy", int'(bus.busy), 1);
      apply_stimulus(2'b11, 10, 2'd0);
      apply_stimulus(2'b01, 10, 2'd0);
      apply_stimulus(2'b00, 10, K_INCR);
      check_idle("entry_done_idle");

      // 3: exit twice back to back
      apply_stimulus(2'b01, 10, 2'd0);
      apply_stimulus(2'b11, 10, 2'd0);
      apply_stimulus(2'b10, 10, 2'd0);
      apply_stimulus(2'b00, 10, K_DECR);
      apply_stimulus(2'b01, 10, 2'd0);
      apply_stimulus(2'b11, 10, 2'd0);
      apply_stimulus(2'b10, 10, 2'd0);
      apply_stimulus(2'b00, 10, K_DECR);
      check_idle("exit_done_idle");

      // 4: aborted passages
      apply_stimulus(2'b10, 10, 2'd0);
      apply_stimulus(2'b00, 10, 2'd0);
      check_idle("abort_ent1");
      apply_stimulus(2'b10, 10, 2'd0);
      apply_stimulus(2'b11, 10, 2'd0);
      apply_stimulus(2'b10, 10, 2'd0);
      apply_stimulus(2'b00, 10, 2'd0);
      check_idle("abort_backout");
      apply_stimulus(2'b01, 10, 2'd0);
      apply_stimulus(2'b11, 10, 2'd0);
      apply_stimulus(2'b01, 10, 2'd0);
      apply_stimulus(2'b00, 10, 2'd0);
      check_idle("abort_exit");

      // 5: glitches on the outer beam
      busy_seen = 0;
      apply_stimulus(2'b10, 2, 2'd0);
      apply_stimulus(2'b00, 0, 2'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.busy) busy_seen = 1;
      end
      check_output("glitch2_busy", busy_seen, 0);
      busy_seen = 0;
      apply_stimulus(2'b10, 3, 2'd0);
      apply_stimulus(2'b00, 0, 2'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.busy) busy_seen = 1;
      end
      check_output("glitch3_busy", busy_seen, 1);
      check_idle("glitch3_settled");

      // 6a: simultaneous block is a fault
      apply_stimulus(2'b11, 10, 2'd0);
      check_output("fault_set", int'(bus.fault), 1);
      check_output("fault_busy", int'(bus.busy), 1);
      apply_stimulus(2'b00, 10, 2'd0);
      check_idle("fault_cleared");

      // 6b: reset in ENT2, still both blocked afterwards
      apply_stimulus(2'b10, 10, 2'd0);
      apply_stimulus(2'b11, 10, 2'd0);
      check_output("ent2_busy", int'(bus.busy), 1);
      #2;
      reset = 1'b1;
      #1;
      check_output("async_reset_outputs", int'({bus.incr, bus.decr, bus.busy, bus.fault}), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_output("post_reset_fault", int'(bus.fault), 1);
      apply_stimulus(2'b00, 10, 2'd0);
      check_idle("post_reset_cleared");

      repeat (10) @(posedge clk);
      check_output("pending_pulses", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
